db15_joy_responder: RTL and testbench

- Device-side emulation of the DB15 serial joystick adapter (two cascaded parallel-in/serial-out shift registers).
- The host drives joy_load and joy_clk. The block presents two players' button states serially on joy_data.
- Used for board loopback and for feeding a second MiSTer from local USB or keyboard inputs.
- Sits on the user-port pins, opposite the existing DB15 reader.

---
 rtl/db15_joy_responder.sv | 114 +++++++++++
 tb/tb_db15_joy_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/db15_joy_responder.sv
// DB15 serial joystick device-side responder.
// Emulates two cascaded PISO shift registers clocked by the host.
module db15_joy_responder #(
  parameter int NBITS       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1048576
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             joy_clk,
  input  logic             joy_load,
  input  logic [NBITS-1:0] p1_btn,
  input  logic [NBITS-1:0] p2_btn,
  output logic             joy_data,
  output logic             frame_done,
  output logic             link_active
);

  localparam int FW = 2 * NBITS;
  localparam int CW = $clog2(FW + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   sclk_q;
  logic                   sload_q;
  logic                   sclk;
  logic                   sload;
  logic                   sclk_rise;
  logic                   sload_fall;
  logic [FW-1:0]          frame;
  logic [FW-1:0]          sr;
  logic [CW-1:0]          cnt;
  logic [TW-1:0]          tcnt;

  assign sclk       = clk_sync[SYNC_STAGES-1];
  assign sload      = load_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk & ~sclk_q;
  assign sload_fall = ~sload & sload_q;
  assign frame      = {~p2_btn, ~p1_btn};

  // Lines rest at their idle levels so reset never fakes an edge
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      clk_sync  <= '0;
      load_sync <= '1;
      sclk_q    <= 1'b0;
      sload_q   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk};
      load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load};
      sclk_q    <= sclk;
      sload_q   <= sload;
    end
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sr         <= '1;
      cnt        <= '0;
      joy_data   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      joy_data   <= (state == LOAD || state == SHIFT)
                    ? sr[0] : 1'b1;
      if (!sload) begin
        // Transparent load; also beats a coincident sclk edge
        state <= LOAD;
        sr    <= frame;
        cnt   <= '0;
      end else begin
        unique case (state)
          LOAD:  state <= SHIFT;
          SHIFT: begin
            if (sclk_rise) begin
              sr  <= {1'b1, sr[FW-1:1]};
              cnt <= cnt + 1'b1;
              if (cnt == CW'(FW - 1)) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      tcnt        <= '0;
      link_active <= 1'b0;
    end else if (sload_fall) begin
      tcnt        <= '0;
      link_active <= 1'b1;
    end else if (tcnt != TW'(TIMEOUT)) begin
      tcnt <= tcnt + 1'b1;
      if (tcnt == TW'(TIMEOUT - 1))
        link_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_db15_joy_responder.sv
// Bench for db15_joy_responder: host-side protocol driver
// with a bit-level reference of the expected serial stream.
module tb_db15_joy_responder;

  localparam int N  = 12;
  localparam int S  = 2;
  localparam int TO = 4096;
  localparam int H  = S + 4;

  logic         clk_sys = 1'b0;
  logic         reset = 1'b0;
  logic         joy_clk = 1'b0;
  logic         joy_load = 1'b1;
  logic [N-1:0] p1_btn = '0;
  logic [N-1:0] p2_btn = '0;
  logic         joy_data;
  logic         frame_done;
  logic         link_active;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;
  logic [N-1:0] ra, rb, rc, rd;

  db15_joy_responder #(
    .NBITS(N),
    .SYNC_STAGES(S),
    .TIMEOUT(TO)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .joy_clk(joy_clk),
    .joy_load(joy_load),
    .p1_btn(p1_btn),
    .p2_btn(p2_btn),
    .joy_data(joy_data),
    .frame_done(frame_done),
    .link_active(link_active)
  );

  always #10 clk_sys = ~clk_sys;

  always @(posedge clk_sys)
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Host sees pressed buttons as 0, player 1 first, bit 0 first
  function automatic logic ref_bit(input logic [N-1:0] a,
                                   input logic [N-1:0] b,
                                   input int k);
    if (k < N) return !a[k];
    return !b[k-N];
  endfunction

  task automatic pulse();
    joy_clk = 1'b1;
    cyc(H);
    joy_clk = 1'b0;
    cyc(H);
  endtask

  task automatic do_load(input logic [N-1:0] a,
                         input logic [N-1:0] b);
    p1_btn   = a;
    p2_btn   = b;
    joy_load = 1'b0;
    cyc(8);
    joy_load = 1'b1;
    cyc(H);
  endtask

  task automatic shift_bits(input logic [N-1:0] a,
                            input logic [N-1:0] b,
                            input int n);
    int s0;
    s0 = done_cnt;
    for (int k = 0; k < n; k++) begin
      check($sformatf("bit%0d", k), 32'(joy_data),
            32'(ref_bit(a, b, k)));
      if (k == 2*N-1)
        check("done_early", done_cnt, s0);
      pulse();
    end
    if (n == 2*N) begin
      check("done_once", done_cnt, s0 + 1);
      check("data_after", 32'(joy_data), 32'd1);
    end
  endtask

  initial begin
    cyc(3);
    check("rst_data", 32'(joy_data), 32'd1);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_link", 32'(link_active), 32'd0);
    reset = 1'b1;
    repeat (5) begin
      cyc(40);
      check("idle_data", 32'(joy_data), 32'd1);
      check("idle_link", 32'(link_active), 32'd0);
      check("idle_done", done_cnt, 0);
    end

    joy_load = 1'b0;
    cyc(1);
    check("link_pre", 32'(link_active), 32'd0);
    cyc(3);
    check("link_up", 32'(link_active), 32'd1);
    cyc(4);
    joy_load = 1'b1;
    cyc(992);
    repeat (2) begin
      joy_load = 1'b0;
      cyc(8);
      joy_load = 1'b1;
      cyc(992);
      check("link_hold", 32'(link_active), 32'd1);
    end
    joy_load = 1'b0;
    cyc(8);
    joy_load = 1'b1;
    cyc(4090);
    check("link_last", 32'(link_active), 32'd1);
    cyc(1);
    check("link_drop", 32'(link_active), 32'd0);

    do_load(12'h011, 12'h800);
    shift_bits(12'h011, 12'h800, 2*N);
    d0 = done_cnt;
    repeat (6) begin
      pulse();
      check("extra_data", 32'(joy_data), 32'd1);
    end
    check("extra_done", done_cnt, d0);

    rb = 12'($urandom);
    do_load(12'h001, rb);
    cyc(3);
    p1_btn = 12'h000;
    p2_btn = ~rb;
    shift_bits(12'h001, rb, 2*N);

    ra = 12'($urandom);
    rb = 12'($urandom);
    rc = 12'($urandom);
    rd = 12'($urandom);
    do_load(ra, rb);
    shift_bits(ra, rb, 7);
    p1_btn   = rc;
    p2_btn   = rd;
    joy_load = 1'b0;
    joy_clk  = 1'b1;
    cyc(8);
    joy_load = 1'b1;
    cyc(H);
    joy_clk = 1'b0;
    cyc(H);
    shift_bits(rc, rd, 2*N);

    repeat (4) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      do_load(ra, rb);
      shift_bits(ra, rb, 2*N);
    end

    ra = 12'($urandom);
    rb = 12'($urandom);
    do_load(ra, rb);
    shift_bits(ra, rb, 10);
    #3 reset = 1'b0;
    #1;
    check("arst_data", 32'(joy_data), 32'd1);
    check("arst_done", 32'(frame_done), 32'd0);
    check("arst_link", 32'(link_active), 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(2);
    pulse();
    check("post_rst_idle", 32'(joy_data), 32'd1);
    rc = 12'($urandom);
    rd = 12'($urandom);
    do_load(rc, rd);
    shift_bits(rc, rd, 2*N);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
